// File: rtl/instruction_sequencer.sv
// Program-memory sequencer: loads a program through a write port, then issues one instruction per cycle to the cpu.
// Handles cpu stalls, HALT_WORD, length and abort. Define SEQ_LOOP_EN to make the program loop at its length.
module instruction_sequencer #(
    parameter int          DEPTH     = 1024,
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
    parameter logic [31:0] NOP_WORD  = 32'h0000_0000
) (
    input  logic              clock_in,
    input  logic              reset_n_in,
    input  logic              load_en_in,
    input  logic [ADDR_W-1:0] load_addr_in,
    input  logic [31:0]       load_data_in,
    input  logic [ADDR_W:0]   program_length_in,
    input  logic              start_in,
    input  logic              stop_in,
    input  logic              cpu_ready_in,
    output logic [31:0]       current_instruction,
    output logic              instruction_valid,
    output logic [ADDR_W-1:0] pc_out,
    output logic              busy,
    output logic              done,
    output logic              halted_on_word
`ifdef SEQ_LOOP_EN
    ,
    output logic [15:0]       loop_count
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] fetch_q, fetch_d;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              valid_d;
    logic              halted_d;
    logic              rd_en;
    logic              instr_clear;
    logic              mem_we;
    logic              accept;
    logic              advance;
    logic              last_word;
`ifdef SEQ_LOOP_EN
    logic [15:0]       loop_d;
`endif

    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign accept    = instruction_valid & cpu_ready_in;
    assign advance   = ~instruction_valid | cpu_ready_in;
    // cnt_q counts words placed in the output register this pass; equal to len_q means the L-th is presented.
    assign last_word = (cnt_q == len_q);
    assign mem_we    = load_en_in & (state_q != ST_RUN);

    // NOTE: program memory has no reset so it maps onto block RAM; its contents survive reset by design.
    always_ff @(posedge clock_in) begin
        if (mem_we) begin
            mem[load_addr_in] <= load_data_in;
        end
    end

    // Synchronous read straight into the output register; reads only happen in RUN, when writes are blocked.
    always_ff @(posedge clock_in) begin
        if (!reset_n_in) begin
            current_instruction <= NOP_WORD;
        end else if (instr_clear) begin
            current_instruction <= NOP_WORD;
        end else if (rd_en) begin
            current_instruction <= mem[rd_addr];
        end
    end

    // NOTE: every register below is updated with <= so all of them see pre-edge values of each other.
    always_ff @(posedge clock_in) begin
        if (!reset_n_in) begin
            state_q           <= ST_IDLE;
            instruction_valid <= 1'b0;
            pc_out            <= '0;
            fetch_q           <= '0;
            len_q             <= '0;
            cnt_q             <= '0;
            halted_on_word    <= 1'b0;
`ifdef SEQ_LOOP_EN
            loop_count        <= '0;
`endif
        end else begin
            state_q           <= state_d;
            instruction_valid <= valid_d;
            pc_out            <= pc_d;
            fetch_q           <= fetch_d;
            len_q             <= len_d;
            cnt_q             <= cnt_d;
            halted_on_word    <= halted_d;
`ifdef SEQ_LOOP_EN
            loop_count        <= loop_d;
`endif
        end
    end

    // NOTE: every output of this block gets a default first, so no path can leave a latch behind.
    always_comb begin
        state_d     = state_q;
        valid_d     = instruction_valid;
        pc_d        = pc_out;
        fetch_d     = fetch_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        halted_d    = halted_on_word;
        rd_en       = 1'b0;
        rd_addr     = fetch_q;
        instr_clear = 1'b0;
`ifdef SEQ_LOOP_EN
        loop_d      = loop_count;
`endif

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_in) begin
                    halted_d = 1'b0;
                    if (program_length_in == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                        len_d   = program_length_in;
                        cnt_d   = '0;
                        fetch_d = '0;
`ifdef SEQ_LOOP_EN
                        loop_d  = '0;
`endif
                    end
                end
            end

            ST_RUN: begin
                if (stop_in) begin
                    state_d     = ST_IDLE;
                    valid_d     = 1'b0;
                    instr_clear = 1'b1;
                end else if (accept && current_instruction == HALT_WORD) begin
                    state_d     = ST_DONE;
                    halted_d    = 1'b1;
                    valid_d     = 1'b0;
                    instr_clear = 1'b1;
                end else if (accept && last_word) begin
`ifdef SEQ_LOOP_EN
                    // Wrap straight back to address 0 without an empty cycle.
                    rd_en   = 1'b1;
                    rd_addr = '0;
                    pc_d    = '0;
                    fetch_d = ADDR_W'(1);
                    cnt_d   = (ADDR_W+1)'(1);
                    valid_d = 1'b1;
                    loop_d  = (loop_count == 16'hFFFF) ? loop_count : loop_count + 16'd1;
`else
                    state_d     = ST_DONE;
                    valid_d     = 1'b0;
                    instr_clear = 1'b1;
`endif
                end else if (advance && !last_word) begin
                    rd_en   = 1'b1;
                    rd_addr = fetch_q;
                    pc_d    = fetch_q;
                    fetch_d = fetch_q + ADDR_W'(1);
                    cnt_d   = cnt_q + (ADDR_W+1)'(1);
                    valid_d = 1'b1;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                valid_d     = 1'b0;
                instr_clear = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed scoreboard bench for instruction_sequencer: expected issues are queued from a shadow memory
// and popped as the cpu side accepts them.
module tb_instruction_sequencer;

    localparam int          DEPTH  = 1024;
    localparam int          ADDR_W = 10;
    localparam logic [31:0] HALT   = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP    = 32'h0000_0000;

    logic              clock_in = 1'b0;
    logic              reset_n_in = 1'b0;
    logic              load_en_in = 1'b0;
    logic [ADDR_W-1:0] load_addr_in = '0;
    logic [31:0]       load_data_in = '0;
    logic [ADDR_W:0]   program_length_in = '0;
    logic              start_in = 1'b0;
    logic              stop_in = 1'b0;
    logic              cpu_ready_in = 1'b0;
    logic [31:0]       current_instruction;
    logic              instruction_valid;
    logic [ADDR_W-1:0] pc_out;
    logic              busy;
    logic              done;
    logic              halted_on_word;
`ifdef SEQ_LOOP_EN
    logic [15:0]       loop_count;
`endif

    instruction_sequencer #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) dut (
        .clock_in           (clock_in),
        .reset_n_in         (reset_n_in),
        .load_en_in         (load_en_in),
        .load_addr_in       (load_addr_in),
        .load_data_in       (load_data_in),
        .program_length_in  (program_length_in),
        .start_in           (start_in),
        .stop_in            (stop_in),
        .cpu_ready_in       (cpu_ready_in),
        .current_instruction(current_instruction),
        .instruction_valid  (instruction_valid),
        .pc_out             (pc_out),
        .busy               (busy),
        .done               (done),
        .halted_on_word     (halted_on_word)
`ifdef SEQ_LOOP_EN
        ,
        .loop_count         (loop_count)
`endif
    );

    always #5 clock_in = ~clock_in;

    typedef struct {
        logic [31:0]       instr;
        logic [ADDR_W-1:0] pc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_mem [DEPTH];
    int          checks = 0;
    int          errors = 0;
    int          cycles;

    task automatic tick();
        @(posedge clock_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h required=%h", tag, observed, expected);
        end
    endtask

    task automatic load_word(input int addr, input logic [31:0] data);
        load_en_in   = 1'b1;
        load_addr_in = ADDR_W'(addr);
        load_data_in = data;
        tick();
        load_en_in   = 1'b0;
        model_mem[addr] = data;
    endtask

    // Expected issue order: words 0..len-1 from the shadow memory, cut short after a HALT word.
    task automatic build_expected(input int len);
        exp_t e;
        exp_q.delete();
        for (int i = 0; i < len; i++) begin
            e.instr = model_mem[i % DEPTH];
            e.pc    = ADDR_W'(i);
            exp_q.push_back(e);
            if (e.instr == HALT) break;
        end
    endtask

    // Starts a run and plays the cpu side until done; stalls stall_n cycles on stall_pc and optionally
    // attempts a write to address 1 in the first RUN cycle.
    task automatic run_program(input int len, input int stall_pc, input int stall_n, input bit poke,
                               output int n_cycles);
        int stall_left;
        build_expected(len);
        program_length_in = (ADDR_W+1)'(len);
        start_in = 1'b1;
        tick();
        start_in   = 1'b0;
        load_en_in = 1'b0;
        check("start_busy", 32'(busy), 32'd1);
        check("start_latency_no_valid", 32'(instruction_valid), 32'd0);
        n_cycles   = 0;
        stall_left = stall_n;
        while (done !== 1'b1 && n_cycles < 3000) begin
            cpu_ready_in = 1'b1;
            if (instruction_valid === 1'b1 && int'(pc_out) == stall_pc && stall_left > 0) begin
                cpu_ready_in = 1'b0;
                stall_left--;
            end
            load_en_in   = poke && n_cycles == 0;
            load_addr_in = ADDR_W'(1);
            load_data_in = 32'hDEAD_BEEF;
            if (instruction_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("extra_issue", 32'(exp_q.size()), 32'd1);
                end else begin
                    check("issue_instr", current_instruction, exp_q[0].instr);
                    check("issue_pc", 32'(pc_out), 32'(exp_q[0].pc));
                    if (cpu_ready_in) void'(exp_q.pop_front());
                end
            end
            tick();
            n_cycles++;
        end
        load_en_in   = 1'b0;
        cpu_ready_in = 1'b0;
        check("run_reaches_done", 32'(done), 32'd1);
        check("all_issued", 32'(exp_q.size()), 32'd0);
        check("done_no_valid", 32'(instruction_valid), 32'd0);
        check("done_nop", current_instruction, NOP);
        check("done_not_busy", 32'(busy), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_instr"}, current_instruction, NOP);
        check({tag, "_valid"}, 32'(instruction_valid), 32'd0);
        check({tag, "_pc"}, 32'(pc_out), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_halted"}, 32'(halted_on_word), 32'd0);
    endtask

    initial begin
        reset_n_in = 1'b0;
        tick();
        tick();
        check_reset_outputs("reset");
        reset_n_in = 1'b1;
        tick();

        load_word(0, 32'h11);
        load_word(1, 32'h22);
        load_word(2, 32'h33);
        load_word(3, 32'h44);

`ifdef SEQ_LOOP_EN
        load_word(0, 32'h5);
        load_word(1, 32'h6);
        exp_q.delete();
        for (int k = 0; k < 6; k++) exp_q.push_back('{instr: model_mem[k % 2], pc: ADDR_W'(k % 2)});
        program_length_in = (ADDR_W+1)'(2);
        start_in = 1'b1;
        cpu_ready_in = 1'b1;
        tick();
        start_in = 1'b0;
        tick();
        for (int k = 0; k < 6; k++) begin
            check("loop_valid", 32'(instruction_valid), 32'd1);
            check("loop_instr", current_instruction, exp_q[0].instr);
            check("loop_pc", 32'(pc_out), 32'(exp_q[0].pc));
            void'(exp_q.pop_front());
            if (k < 5) tick();
        end
        check("loop_count_two", 32'(loop_count), 32'd2);
        check("loop_still_busy", 32'(busy), 32'd1);
        stop_in = 1'b1;
        tick();
        stop_in = 1'b0;
        cpu_ready_in = 1'b0;
        check("loop_stop_idle", 32'(busy), 32'd0);
        check("loop_stop_no_valid", 32'(instruction_valid), 32'd0);
`else
        // Basic run: four words back to back, then DONE on length.
        run_program(4, -1, 0, 1'b0, cycles);
        check("basic_cycles", 32'(cycles), 32'd5);
        check("basic_last_pc", 32'(pc_out), 32'd3);
        check("basic_not_halted", 32'(halted_on_word), 32'd0);

        // Stall three cycles on 0x22.
        run_program(4, 1, 3, 1'b0, cycles);
        check("stall_cycles", 32'(cycles), 32'd8);

        // Write to address 1 while running is dropped; a rerun still shows 0x22.
        run_program(4, -1, 0, 1'b1, cycles);
        run_program(4, -1, 0, 1'b0, cycles);
        check("poke_rerun_cycles", 32'(cycles), 32'd5);

        // Abort at pc 2; stop wins over the simultaneous accept.
        program_length_in = (ADDR_W+1)'(4);
        start_in = 1'b1;
        cpu_ready_in = 1'b1;
        tick();
        start_in = 1'b0;
        cycles = 0;
        while (!(instruction_valid === 1'b1 && pc_out == ADDR_W'(2)) && cycles < 20) begin
            tick();
            cycles++;
        end
        check("abort_reach_pc2", 32'(pc_out), 32'd2);
        stop_in = 1'b1;
        tick();
        stop_in = 1'b0;
        check("abort_not_busy", 32'(busy), 32'd0);
        check("abort_not_done", 32'(done), 32'd0);
        check("abort_no_valid", 32'(instruction_valid), 32'd0);
        check("abort_nop", current_instruction, NOP);
        tick();
        check("abort_stays_idle", 32'(instruction_valid), 32'd0);
        cpu_ready_in = 1'b0;

        // Reset mid-run, then rerun from retained memory.
        program_length_in = (ADDR_W+1)'(4);
        start_in = 1'b1;
        cpu_ready_in = 1'b1;
        tick();
        start_in = 1'b0;
        tick();
        tick();
        check("midrst_was_running", 32'(instruction_valid), 32'd1);
        reset_n_in = 1'b0;
        tick();
        reset_n_in = 1'b1;
        cpu_ready_in = 1'b0;
        check_reset_outputs("midrst");
        run_program(4, -1, 0, 1'b0, cycles);
        check("midrst_rerun_cycles", 32'(cycles), 32'd5);

        // HALT word in the middle of a three-word program.
        load_word(0, 32'hA);
        load_word(1, HALT);
        load_word(2, 32'hB);
        run_program(3, -1, 0, 1'b0, cycles);
        check("halt_cycles", 32'(cycles), 32'd3);
        check("halt_flag", 32'(halted_on_word), 32'd1);
        check("halt_last_pc", 32'(pc_out), 32'd1);

        reset_n_in = 1'b0;
        tick();
        reset_n_in = 1'b1;
        check_reset_outputs("donerst");

        run_program(3, -1, 0, 1'b0, cycles);
        check("halt2_flag", 32'(halted_on_word), 32'd1);

        // Zero length: straight to DONE, halt flag cleared, nothing issued.
        program_length_in = '0;
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        check("len0_done", 32'(done), 32'd1);
        check("len0_halted", 32'(halted_on_word), 32'd0);
        check("len0_no_valid", 32'(instruction_valid), 32'd0);
        check("len0_not_busy", 32'(busy), 32'd0);

        // Start together with a write to address 0: the new word is the one issued.
        load_en_in   = 1'b1;
        load_addr_in = '0;
        load_data_in = 32'h55;
        model_mem[0] = 32'h55;
        run_program(1, -1, 0, 1'b0, cycles);
        check("startload_cycles", 32'(cycles), 32'd2);

        // Full-depth program: every address issued exactly once.
        for (int i = 0; i < DEPTH; i++) load_word(i, 32'h1000_0000 + 32'(i));
        run_program(DEPTH, -1, 0, 1'b0, cycles);
        check("full_cycles", 32'(cycles), 32'(DEPTH + 1));
        check("full_last_pc", 32'(pc_out), 32'(DEPTH - 1));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_sequencer.md
Name: instruction_sequencer

Overview:
- Owns program memory for `cpu` and replaces hand-driven instruction feeding: the program is loaded through a write port, then instructions are issued one per cycle on `current_instruction`.
- Sits directly upstream of the cpu's `current_instruction` input and shares `clock_in`.
- Handles start, stall (cpu back-pressure), halt-word detection, end-of-program and abort.

Parameters:
- DEPTH, 1024, program memory depth in 32-bit words (power of two).
- ADDR_W, 10, address width; equals log2(DEPTH).
- HALT_WORD, 32'hFFFF_FFFF, instruction value that terminates a run.
- NOP_WORD, 32'h0000_0000, value driven on current_instruction when no valid instruction is presented.

Ports:
- clock_in  input  1  system clock; all logic on its rising edge.
- reset_n_in  input  1  synchronous, active-low reset.
- load_en_in  input  1  write program word; honoured only in IDLE or DONE.
- load_addr_in  input  ADDR_W  program write address.
- load_data_in  input  32  program write data.
- program_length_in  input  ADDR_W+1  number of words to run (0..DEPTH); sampled on start.
- start_in  input  1  begin run from address 0; honoured only in IDLE or DONE.
- stop_in  input  1  abort run.
- cpu_ready_in  input  1  cpu accepts the presented instruction this cycle.
- current_instruction  output  32  instruction to cpu (registered).
- instruction_valid  output  1  current_instruction holds a real instruction.
- pc_out  output  ADDR_W  address of the instruction currently presented.
- busy  output  1  state is RUN.
- done  output  1  state is DONE.
- halted_on_word  output  1  last run ended on HALT_WORD rather than length.

Behaviour:
- Reset (reset_n_in=0 at an edge): state=IDLE, current_instruction=NOP_WORD, instruction_valid=0, pc_out=0, busy=0, done=0, halted_on_word=0. Memory contents are not cleared. Reset overrides every other input, including mid-run.
- States: IDLE, RUN, DONE.
- IDLE/DONE:
  - load_en_in writes mem[load_addr_in] <= load_data_in.
  - start_in with program_length_in=0: go to DONE, halted_on_word=0, nothing issued.
  - start_in with program_length_in>0: latch length L, clear done and halted_on_word, go to RUN.
  - The first instruction mem[0] appears registered on the cycle after entering RUN (start-to-first-valid latency = 2 edges).
- Writes in RUN are ignored and do not corrupt memory.
- RUN issue rule: the output register advances when instruction_valid=0 or cpu_ready_in=1.
  - On advance with words remaining: current_instruction <= mem[fetch_ptr], pc_out <= fetch_ptr, valid=1, fetch_ptr++.
  - Memory read is synchronous, one cycle.
  - When valid=1 and cpu_ready_in=0: current_instruction, pc_out and valid hold unchanged (stall). No skips or duplicates.
- Termination:
  - HALT_WORD: issued to the cpu like any other word. On its acceptance (valid & ready), go to DONE with halted_on_word=1.
  - Length: after the L-th word is accepted, go to DONE with halted_on_word=0.
  - A HALT_WORD at position L counts as halt (halted_on_word=1).
  - On entering DONE: valid=0 and current_instruction=NOP_WORD the next cycle; pc_out holds the last issued address.
- stop_in in RUN: next edge goes to IDLE, valid=0, NOP driven, done=0. stop_in outranks a simultaneous accept. stop_in is ignored outside RUN.
- start_in and load_en_in in the same cycle: the write happens, and the run starts from the pre-write memory for address 0 only if load_addr_in≠0. Same-address read/write conflicts return the new data (write-first).
- fetch_ptr wraps modulo DEPTH. With L=DEPTH, all words are issued exactly once.

Optional Feature:
- SEQ_LOOP_EN defined:
  - Reaching length L (not HALT_WORD) restarts issue at address 0 with no bubble beyond the normal one-cycle read, staying in RUN.
  - Only HALT_WORD or stop_in ends the run.
  - Adds output loop_count (16 bits, saturating), incremented on each wrap, cleared on start.
- SEQ_LOOP_EN undefined: length-based termination to DONE as above; no loop_count port.

Test Plan:
- Basic run: load mem[0..3]=32'h11,22,33,44, L=4, ready=1 → valid sequence 11,22,33,44 on consecutive cycles, pc_out 0..3; then done=1, halted_on_word=0, NOP driven.
- Stall: same program, cpu_ready_in=0 for 3 cycles while 32'h22 is presented → 32'h22 and pc_out=1 held for 4 cycles, then 33,44; no duplicates.
- Halt word: mem[0..2]=32'hA,32'hFFFF_FFFF,32'hB, L=3 → issues A then FFFF_FFFF, never B; done=1, halted_on_word=1.
- Abort and reset: stop_in asserted while pc_out=2 → IDLE next edge, valid=0. Separately, reset_n_in=0 mid-run → all outputs at reset values; memory retained, so a rerun reproduces the program.
- Edge cases: start with L=0 → DONE, no valid. load_en_in during RUN to addr 1 → memory unchanged on rerun. L=1024 → 1024 issues, last pc_out=1023.
- SEQ_LOOP_EN: L=2, mem=5,6, ready=1 for 6 cycles → 5,6,5,6,5,6; loop_count=2 after the second wrap.
